// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and MTHI/MTLO writes.
// Optional macro MULDIV_DIVZERO_EN adds a div_zero flag and leaves HI/LO untouched on divide by zero.
module muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
`ifdef MULDIV_DIVZERO_EN
   output logic             div_zero,
`endif
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_isDiv;
   logic               r_negRes;
   logic               r_negRem;
   logic               r_divZero;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_acc;
`ifdef MULDIV_DIVZERO_EN
   logic               r_dzFlag;
`endif

   logic               w_isMulDiv;
   logic               w_signed;
   logic               w_aNeg;
   logic               w_bNeg;
   logic               w_divGe;
   logic [WIDTH-1:0]   w_aMag;
   logic [WIDTH-1:0]   w_bMag;
   logic [WIDTH-1:0]   w_divDiff;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH:0]     w_mulSum;
   logic [WIDTH:0]     w_divShift;
   logic [2*WIDTH-1:0] w_mulNext;
   logic [2*WIDTH-1:0] w_divNext;
   logic [2*WIDTH-1:0] w_prod;

   assign w_isMulDiv = (op[2] == 1'b0);
   assign w_signed   = w_isMulDiv && !op[0];
   assign w_aNeg     = w_signed && A[WIDTH-1];
   assign w_bNeg     = w_signed && B[WIDTH-1];
   assign w_aMag     = w_aNeg ? (~A + 1'b1) : A;
   assign w_bMag     = w_bNeg ? (~B + 1'b1) : B;

   // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
   assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
   assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_divGe    = (w_divShift >= {1'b0, r_opnd});
   assign w_divDiff  = WIDTH'(w_divShift - {1'b0, r_opnd});
   assign w_divNext  = w_divGe ? {w_divDiff, r_acc[WIDTH-2:0], 1'b1}
                               : {w_divShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

   // A zero divisor keeps the raw all-ones quotient; the remainder fix restores the original dividend.
   assign w_prod = r_negRes ? (~r_acc + 1'b1) : r_acc;
   assign w_quot = (r_negRes && !r_divZero) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
   assign w_rem  = r_negRem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;
`ifdef MULDIV_DIVZERO_EN
   assign div_zero = r_dzFlag;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_isDiv   <= 1'b0;
         r_negRes  <= 1'b0;
         r_negRem  <= 1'b0;
         r_divZero <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_opnd    <= '0;
         r_acc     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
`ifdef MULDIV_DIVZERO_EN
         r_dzFlag  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
         r_dzFlag <= 1'b0;
`endif
         if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  r_state <= S_IDLE;
                  if (start) begin
                     if (w_isMulDiv) begin
                        r_state   <= S_CALC;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_isDiv   <= op[1];
                        r_negRes  <= w_aNeg ^ w_bNeg;
                        r_negRem  <= w_aNeg;
                        r_divZero <= (B == '0);
                        r_opnd    <= op[1] ? w_bMag : w_aMag;
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_aMag : w_bMag)};
                     end else if (op == OP_MTHI) begin
                        r_hi <= A;
                     end else if (op == OP_MTLO) begin
                        r_lo <= A;
                     end
                  end
               end
               S_CALC: begin
                  r_acc <= r_isDiv ? w_divNext : w_mulNext;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(WIDTH - 1)) begin
                     r_state <= S_FIX;
                  end
               end
               S_FIX: begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  if (!r_isDiv) begin
                     {r_hi, r_lo} <= w_prod;
`ifdef MULDIV_DIVZERO_EN
                  end else if (r_divZero) begin
                     r_dzFlag <= 1'b1;
`endif
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quot;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
